spi_responder: RTL and testbench

- SPI slave-side counterpart to the SPI_driver master: Mode 1 (CPOL=0, CPHA=1), MSB first, 8-bit frames.
- Oversamples SPI_CLK, SPI_EN and SPI_MOSI in the system clock domain. Shifts out a byte on SPI_MISO while shifting in a byte from SPI_MOSI.
- Presents received bytes on a valid pulse and accepts transmit bytes through a one-entry valid/ready holding register.
- Supports back-to-back bytes within a single SPI_EN-low frame.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 45 ++++
 rtl/spi_responder.sv | 212 +++++++++++++++++++++
 tb/tb_spi_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    // Byte sent to the master whenever nothing is waiting in the holding register
    localparam logic [SPI_BYTE_W-1:0] C_DUMMY_BYTE = 8'hFF;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        SELECTED = 1'b1
    } spi_resp_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Multi-flop synchronizer followed by an edge-detect flop.
//                level/rise/fall are valid SYNC_STAGES clk after the pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2   // legal values: 2 or 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Metastability chain; resets low so a pin held low through reset gives no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    // Previous synchronized level, used for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_responder
//  Description : SPI Mode 1 (CPOL=0, CPHA=1) slave, MSB first, 8-bit frames,
//                oversampled in the clk domain, with a one-entry TX holding
//                register and back-to-back bytes within one SPI_EN frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_responder
    import spi_pkg::*;
#(
    parameter logic [SPI_BYTE_W-1:0] DUMMY_BYTE  = C_DUMMY_BYTE,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SPI_CLK,
    input  logic                  SPI_EN,
    input  logic                  SPI_MOSI,
    output logic                  SPI_MISO,
    output logic                  SPI_MISO_oe,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_abort
);

    localparam int                 C_CNT_W    = $clog2(SPI_BYTE_W);
    localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(SPI_BYTE_W - 1);

    // ------------------------------------------------------------------------
    // Synchronized pin views
    // ------------------------------------------------------------------------
    logic w_sck_rise, w_sck_fall, w_en_rise, w_en_fall, w_mosi_s;
    logic w_unused_sck_lvl, w_unused_en_lvl, w_unused_mosi_rise, w_unused_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SPI_CLK),
        .level (w_unused_sck_lvl),
        .rise  (w_sck_rise),
        .fall  (w_sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SPI_EN),
        .level (w_unused_en_lvl),
        .rise  (w_en_rise),
        .fall  (w_en_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SPI_MOSI),
        .level (w_mosi_s),
        .rise  (w_unused_mosi_rise),
        .fall  (w_unused_mosi_fall)
    );

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    spi_resp_state_t       r_state, w_state_nxt;
    logic [SPI_BYTE_W-1:0] r_tx_shift, r_rx_shift, r_hold, r_rx_data;
    logic [C_CNT_W-1:0]    r_bit_cnt;
    logic                  r_hold_full;
    logic                  r_miso, r_miso_oe;
    logic                  r_rx_valid, r_tx_underrun, r_frame_abort;
    logic                  r_dummy_pend;

    // Control strobes decoded from state and synchronized edges
    logic                  w_load_start, w_end_frame, w_shift_out, w_shift_in, w_byte_done;
    logic                  w_load, w_accept;
    logic [SPI_BYTE_W-1:0] w_load_byte, w_rx_next;

    assign w_load      = w_load_start | w_byte_done;
    assign w_accept    = tx_valid & ~r_hold_full;
    assign w_load_byte = r_hold_full ? r_hold : DUMMY_BYTE;
    assign w_rx_next   = {r_rx_shift[SPI_BYTE_W-2:0], w_mosi_s};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle strobes; SPI_EN rising masks any SCK edge in the same clk
    always_comb begin
        w_state_nxt  = r_state;
        w_load_start = 1'b0;
        w_end_frame  = 1'b0;
        w_shift_out  = 1'b0;
        w_shift_in   = 1'b0;
        w_byte_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_en_fall) begin
                    w_state_nxt  = SELECTED;
                    w_load_start = 1'b1;
                end
            end
            SELECTED: begin
                if (w_en_rise) begin
                    w_state_nxt = IDLE;
                    w_end_frame = 1'b1;
                end else begin
                    w_shift_out = w_sck_rise;
                    w_shift_in  = w_sck_fall;
                    w_byte_done = w_sck_fall && (r_bit_cnt == C_LAST_BIT);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Holding register: a same-cycle accept refills it after the load took the old content
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // Transmit path. An in-frame dummy load is only reported as an underrun once
    // that byte actually starts going out, so the trailing load point after a
    // frame's last byte never flags a spurious underrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift    <= '0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_dummy_pend  <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            if (w_end_frame) begin
                r_miso       <= 1'b0;
                r_miso_oe    <= 1'b0;
                r_dummy_pend <= 1'b0;
            end
            if (w_load_start) begin
                r_miso_oe     <= 1'b1;
                r_tx_underrun <= ~r_hold_full;
                r_dummy_pend  <= 1'b0;
            end
            if (w_load) begin
                r_tx_shift <= w_load_byte;
            end else if (w_shift_out) begin
                r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
            end
            if (w_byte_done) begin
                r_dummy_pend <= ~r_hold_full;
            end
            if (w_shift_out) begin
                r_miso <= r_tx_shift[SPI_BYTE_W-1];
                if (r_dummy_pend) begin
                    r_tx_underrun <= 1'b1;
                    r_dummy_pend  <= 1'b0;
                end
            end
        end
    end

    // Receive path: sample on SCK falling edges, publish each completed byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_shift    <= '0;
            r_bit_cnt     <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_frame_abort <= w_end_frame && (r_bit_cnt != '0);
            if (w_load_start) begin
                r_bit_cnt <= '0;
            end else if (w_shift_in) begin
                r_rx_shift <= w_rx_next;
                r_bit_cnt  <= r_bit_cnt + 1'b1;
            end
            if (w_byte_done) begin
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
            end
        end
    end

    assign SPI_MISO    = r_miso;
    assign SPI_MISO_oe = r_miso_oe;
    assign tx_ready    = ~r_hold_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;
    assign frame_abort = r_frame_abort;

endmodule : spi_responder
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_responder
//  Description : Self-checking bench for spi_responder: Mode 1 master model,
//                TX holding-register model and RX scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       SPI_CLK = 1'b0;
    logic       SPI_EN = 1'b1;
    logic       SPI_MOSI = 1'b0;
    logic       SPI_MISO, SPI_MISO_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, tx_underrun, frame_abort;

    spi_responder #(.DUMMY_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SPI_CLK     (SPI_CLK),
        .SPI_EN      (SPI_EN),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .SPI_MISO_oe (SPI_MISO_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int underrun_seen = 0;
    int abort_seen = 0;

    // Reference model: one-entry holding register, last received byte, RX expectations
    logic [7:0] m_hold = 8'h00;
    bit         m_hold_full = 1'b0;
    logic [7:0] m_last_rx = 8'h00;
    logic [7:0] rx_exp[$];

    // Per-frame stimulus description
    logic [7:0] f_mosi[4];
    logic [7:0] f_push_val[4];
    logic [7:0] f_sim_val[4];
    bit         f_push_en[4];
    bit         f_sim_en[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_load(output logic [7:0] b, output bit dummy);
        b           = m_hold_full ? m_hold : 8'hFF;
        dummy       = !m_hold_full;
        m_hold_full = 1'b0;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 4; i++) begin
            f_mosi[i] = 8'h00; f_push_val[i] = 8'h00; f_sim_val[i] = 8'h00;
            f_push_en[i] = 1'b0; f_sim_en[i] = 1'b0;
        end
    endtask

    task automatic tx_push(input logic [7:0] v);
        int n = 0;
        tx_data  = v;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL tx_push_timeout: tx_ready=%b, expected 1", tx_ready);
        end
        tick(1);
        tx_valid    = 1'b0;
        m_hold      = v;
        m_hold_full = 1'b1;
    endtask

    // Scoreboard monitor: every rx_valid pops one expected byte; count pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid === 1'b1) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got rx_valid with %0h, expected none", rx_data);
                end else begin
                    check("rx_data", rx_data, rx_exp.pop_front());
                end
            end
            if (tx_underrun === 1'b1) underrun_seen++;
            if (frame_abort === 1'b1) abort_seen++;
        end
    end

    // Mode 1 master: drive on SCK rise, sample MISO at SCK fall, 4 clk per phase
    task automatic run_frame(input int n, input int abort_falls);
        logic [7:0] cur, nxt, rcv;
        bit         dummy, aborted;
        int         u0, a0, exp_u, falls;
        u0 = underrun_seen; a0 = abort_seen;
        exp_u = 0; falls = 0; aborted = 1'b0; nxt = 8'h00;
        SPI_EN = 1'b0;
        model_load(cur, dummy);
        if (dummy) exp_u++;
        tick(6);
        check("miso_oe_selected", SPI_MISO_oe, 1);
        for (int i = 0; i < n && !aborted; i++) begin
            rcv = 8'h00;
            for (int b = 7; b >= 0; b--) begin
                SPI_MOSI = f_mosi[i][b];
                SPI_CLK  = 1'b1;
                tick(4);
                if (f_push_en[i] && b == 4) tx_push(f_push_val[i]);
                rcv[b]  = SPI_MISO;
                SPI_CLK = 1'b0;
                falls++;
                if (abort_falls != 0 && falls == abort_falls) begin
                    aborted = 1'b1;
                    tick(4);
                    break;
                end
                if (b == 0) begin
                    rx_exp.push_back(f_mosi[i]);
                    m_last_rx = f_mosi[i];
                    if (f_sim_en[i]) begin
                        // Present tx_valid exactly on the clk that acts on this fall
                        tick(2);
                        check("tx_ready_before_sim", tx_ready, 1);
                        tx_data  = f_sim_val[i];
                        tx_valid = 1'b1;
                        tick(1);
                        tx_valid = 1'b0;
                        model_load(nxt, dummy);
                        m_hold      = f_sim_val[i];
                        m_hold_full = 1'b1;
                        check("tx_ready_after_sim", tx_ready, 0);
                        tick(1);
                    end else begin
                        model_load(nxt, dummy);
                        tick(4);
                    end
                    if (dummy && i < n - 1) exp_u++;
                end else begin
                    tick(4);
                end
            end
            if (!aborted) begin
                check("miso_byte", rcv, cur);
                cur = nxt;
            end
        end
        SPI_EN = 1'b1;
        tick(6);
        check("miso_oe_idle", SPI_MISO_oe, 0);
        check("miso_idle", SPI_MISO, 0);
        check("underrun_count", underrun_seen - u0, exp_u);
        check("abort_count", abort_seen - a0, aborted ? 1 : 0);
        check("rx_data_hold", rx_data, m_last_rx);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check("rst_miso", SPI_MISO, 0);
        check("rst_oe", SPI_MISO_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);

        // Single byte with preload
        clear_frame();
        tx_push(8'hA5);
        check("tx_ready_full", tx_ready, 0);
        f_mosi[0] = 8'h3C;
        run_frame(1, 0);

        // Back-to-back bytes in one frame, second TX byte pushed mid-byte
        clear_frame();
        tx_push(8'h11);
        f_mosi[0] = 8'hC3; f_mosi[1] = 8'h5A;
        f_push_en[0] = 1'b1; f_push_val[0] = 8'h22;
        run_frame(2, 0);

        // Underrun at frame start
        clear_frame();
        f_mosi[0] = 8'h81;
        run_frame(1, 0);

        // Abort after 5 falling edges
        clear_frame();
        f_mosi[0] = 8'hE7;
        run_frame(1, 5);

        // Accept coinciding with the in-frame load point
        clear_frame();
        tx_push(8'h3E);
        f_mosi[0] = 8'h01; f_mosi[1] = 8'h02; f_mosi[2] = 8'h03;
        f_sim_en[0] = 1'b1; f_sim_val[0] = 8'hD7;
        run_frame(3, 0);

        // Reset in the middle of a byte
        SPI_EN = 1'b0;
        tick(6);
        for (int b = 0; b < 3; b++) begin
            SPI_MOSI = 1'b1; SPI_CLK = 1'b1; tick(4);
            SPI_CLK = 1'b0; tick(4);
        end
        SPI_CLK = 1'b1;
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_miso", SPI_MISO, 0);
        check("arst_oe", SPI_MISO_oe, 0);
        check("arst_tx_ready", tx_ready, 1);
        check("arst_rx_data", rx_data, 0);
        check("arst_rx_valid", rx_valid, 0);
        check("arst_underrun", tx_underrun, 0);
        check("arst_abort", frame_abort, 0);
        m_hold_full = 1'b0;
        m_last_rx   = 8'h00;
        SPI_CLK = 1'b0;
        SPI_EN  = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        clear_frame();
        tx_push(8'h69);
        f_mosi[0] = 8'h96;
        run_frame(1, 0);

        // Randomized frames
        for (int k = 0; k < 12; k++) begin
            int n;
            clear_frame();
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) tx_push(8'($urandom));
            for (int i = 0; i < n; i++) begin
                f_mosi[i]    = 8'($urandom);
                f_sim_val[i] = 8'($urandom);
                f_push_val[i] = 8'($urandom);
                f_sim_en[i]  = (i < n - 1) && ($urandom_range(0, 2) == 0);
                f_push_en[i] = !f_sim_en[i] && !(i > 0 && f_sim_en[i-1]) &&
                               ($urandom_range(0, 1) == 1);
            end
            run_frame(n, 0);
        end

        check("rx_queue_drained", rx_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_spi_responder
`default_nettype wire
